// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, LSU and memory-side signals around mem_arbiter.
// The arbiter uses the master view; clients and the memory model use the slave view.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_done;
  logic [31:0] if_rdata;

  logic        lsu_req;
  logic        lsu_we;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_gnt;
  logic        lsu_done;
  logic [31:0] lsu_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic        arb_busy;
  logic        arb_err;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_done, if_rdata,
    input  lsu_req, lsu_we, lsu_size, lsu_addr, lsu_wdata,
    output lsu_gnt, lsu_done, lsu_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output arb_busy, arb_err
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_done, if_rdata,
    output lsu_req, lsu_we, lsu_size, lsu_addr, lsu_wdata,
    input  lsu_gnt, lsu_done, lsu_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  arb_busy, arb_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) single-port memory arbiter with a BUSY timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise LSU wins ties.
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LSU} state_t;

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  state_t      state_reg, state_next;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [7:0]  cnt_reg;
  logic        if_done_reg, lsu_done_reg, err_reg;
  logic [31:0] if_rdata_reg, lsu_rdata_reg;

  logic gnt_if, gnt_lsu, lsu_wins, busy, timeout, finish;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_lsu_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_lsu_reg <= 1'b0;
    else if (gnt_if || gnt_lsu)
      last_lsu_reg <= gnt_lsu;
  end

  assign lsu_wins = !last_lsu_reg;
`else
  assign lsu_wins = 1'b1;
`endif

  assign busy    = (state_reg != IDLE);
  assign timeout = busy && !bus.mem_ready && (cnt_reg == TIMEOUT_LIMIT);
  assign finish  = busy && (bus.mem_ready || timeout);

  always_comb begin
    state_next = state_reg;
    gnt_if     = 1'b0;
    gnt_lsu    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.lsu_req && (lsu_wins || !bus.if_req)) begin
          gnt_lsu    = 1'b1;
          state_next = BUSY_LSU;
        end else if (bus.if_req) begin
          gnt_if     = 1'b1;
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_LSU: begin
        if (finish)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      addr_reg      <= 32'h0;
      wdata_reg     <= 32'h0;
      cnt_reg       <= 8'h0;
      if_done_reg   <= 1'b0;
      lsu_done_reg  <= 1'b0;
      err_reg       <= 1'b0;
      if_rdata_reg  <= 32'h0;
      lsu_rdata_reg <= 32'h0;
    end else begin
      state_reg    <= state_next;
      if_done_reg  <= 1'b0;
      lsu_done_reg <= 1'b0;
      err_reg      <= 1'b0;
      if (gnt_lsu) begin
        we_reg    <= bus.lsu_we;
        size_reg  <= bus.lsu_size;
        addr_reg  <= bus.lsu_addr;
        wdata_reg <= bus.lsu_wdata;
        cnt_reg   <= 8'h0;
      end else if (gnt_if) begin
        we_reg    <= 1'b0;
        size_reg  <= 2'b10;
        addr_reg  <= bus.if_addr;
        wdata_reg <= 32'h0;
        cnt_reg   <= 8'h0;
      end else if (busy && !bus.mem_ready) begin
        cnt_reg <= cnt_reg + 8'h1;
      end
      // Aborted accesses and stores both return zero data.
      if (finish) begin
        err_reg <= timeout;
        if (state_reg == BUSY_IF) begin
          if_done_reg  <= 1'b1;
          if_rdata_reg <= timeout ? 32'h0 : bus.mem_rdata;
        end else begin
          lsu_done_reg  <= 1'b1;
          lsu_rdata_reg <= (timeout || we_reg) ? 32'h0 : bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.lsu_gnt   = gnt_lsu;
  assign bus.if_done   = if_done_reg;
  assign bus.lsu_done  = lsu_done_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.lsu_rdata = lsu_rdata_reg;
  assign bus.arb_busy  = busy;
  assign bus.arb_err   = err_reg;
  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy && we_reg;
  assign bus.mem_size  = busy ? size_reg  : 2'b00;
  assign bus.mem_addr  = busy ? addr_reg  : 32'h0;
  assign bus.mem_wdata = busy ? wdata_reg : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level model predicts grant
// order, memory accesses and completions; a monitor and a memory responder check them.
module tb_mem_arbiter;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();
  mem_arbiter #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    bit          lsu;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    bit          lsu;
    logic [31:0] data;
    bit          err;
    int          at;
  } done_t;

  acc_t  exp_acc[$];
  done_t exp_done[$];
  bit    exp_gnt[$];

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int n_done = 0;
  int last_gnt_cyc = -10;
  bit rr_last_lsu = 1'b0;
  bit hold = 1'b0;
  logic [31:0] last_if = 32'h0, last_lsu = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: grants and completions against the model's queues
  bit    mon_e;
  done_t mon_d;
  always @(negedge clk) begin
    if (rst) begin
      if (bus.if_gnt || bus.lsu_gnt) begin
        check("gnt_onehot", 32'(bus.if_gnt & bus.lsu_gnt), 0);
        check("gnt_while_busy", 32'(bus.arb_busy), 0);
        if (exp_gnt.size() == 0) check("gnt_unexpected", 1, 0);
        else begin
          mon_e = exp_gnt.pop_front();
          check("gnt_owner_is_lsu", 32'(bus.lsu_gnt), 32'(mon_e));
        end
        last_gnt_cyc = cyc;
      end
      if (bus.if_done || bus.lsu_done) begin
        $display("done: %s rdata=%h err=%0b cycle %0d", bus.lsu_done ? "LSU" : "IF",
                 bus.lsu_done ? bus.lsu_rdata : bus.if_rdata, bus.arb_err, cyc);
        if (bus.if_req || bus.lsu_req) check("b2b_gnt", 32'(bus.if_gnt | bus.lsu_gnt), 1);
        check("done_onehot", 32'(bus.if_done & bus.lsu_done), 0);
        if (exp_done.size() == 0) check("done_unexpected", 1, 0);
        else begin
          mon_d = exp_done.pop_front();
          check("done_owner_is_lsu", 32'(bus.lsu_done), 32'(mon_d.lsu));
          check("done_cycle", cyc, mon_d.at);
          check("done_err", 32'(bus.arb_err), 32'(mon_d.err));
          if (mon_d.lsu) begin
            check("lsu_rdata", bus.lsu_rdata, mon_d.data);
            check("if_rdata_hold", bus.if_rdata, last_if);
            last_lsu = mon_d.data;
          end else begin
            check("if_rdata", bus.if_rdata, mon_d.data);
            check("lsu_rdata_hold", bus.lsu_rdata, last_lsu);
            last_if = mon_d.data;
          end
        end
        n_done++;
      end else if (bus.arb_err) begin
        check("err_without_done", 1, 0);
      end
    end
  end

  // Memory responder: checks presented fields, picks a response delay or a timeout
  bit          active = 1'b0, to_plan = 1'b0, stable_bad = 1'b0;
  int          delay_n = 0, wait_n = 0;
  acc_t        cur;
  logic [31:0] rdat;
  always @(negedge clk) begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    if (!rst) begin
      active = 1'b0;
    end else if (bus.mem_req) begin
      if (!active) begin
        active = 1'b1;
        wait_n = 0;
        stable_bad = 1'b0;
        if (exp_acc.size() == 0) begin
          check("mem_access_unexpected", 1, 0);
          cur = '{lsu: 1'b0, we: bus.mem_we, size: bus.mem_size, addr: bus.mem_addr, wdata: bus.mem_wdata};
        end else cur = exp_acc.pop_front();
        check("req_latency", cyc, last_gnt_cyc + 1);
        check("mem_addr", bus.mem_addr, cur.addr);
        check("mem_we", 32'(bus.mem_we), 32'(cur.we));
        check("mem_size", 32'(bus.mem_size), 32'(cur.size));
        if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
        to_plan = !hold && ($urandom_range(0, 5) == 0);
        delay_n = $urandom_range(0, 3);
        if (to_plan) exp_done.push_back('{lsu: cur.lsu, data: 32'h0, err: 1'b1, at: cyc + T + 1});
      end else if (bus.mem_we !== cur.we || bus.mem_addr !== cur.addr || bus.mem_size !== cur.size ||
                   (cur.we && bus.mem_wdata !== cur.wdata)) begin
        stable_bad = 1'b1;
      end
      if (hold) begin
        // leave the access hanging
      end else if (to_plan) begin
        if (wait_n == T) begin
          active = 1'b0;
          check("mem_fields_stable", 32'(stable_bad), 0);
        end
        wait_n++;
      end else if (wait_n == delay_n) begin
        rdat = $urandom;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdat;
        exp_done.push_back('{lsu: cur.lsu, data: cur.we ? 32'h0 : rdat, err: 1'b0, at: cyc + 1});
        active = 1'b0;
        check("mem_fields_stable", 32'(stable_bad), 0);
      end else begin
        wait_n++;
      end
    end else if (active && !hold) begin
      check("mem_req_dropped", 1, 0);
      active = 1'b0;
    end
  end

  // Called just after a rising edge; kind 0 = IF only, 1 = LSU only, 2 = both at once
  task automatic run_round(int kind);
    bit want_if, want_lsu, lsu_first, gi, gl, ok;
    acc_t a_if, a_lsu;
    int target;
    want_if  = (kind != 1);
    want_lsu = (kind != 0);
    target   = n_done + int'(want_if) + int'(want_lsu);
    bus.if_addr   = $urandom;
    bus.lsu_we    = 1'($urandom_range(0, 1));
    bus.lsu_size  = 2'($urandom_range(0, 2));
    bus.lsu_addr  = $urandom;
    bus.lsu_wdata = $urandom;
    a_if  = '{lsu: 1'b0, we: 1'b0, size: 2'b10, addr: bus.if_addr, wdata: 32'h0};
    a_lsu = '{lsu: 1'b1, we: bus.lsu_we, size: bus.lsu_size, addr: bus.lsu_addr, wdata: bus.lsu_wdata};
`ifdef MEM_ARB_ROUND_ROBIN_EN
    lsu_first = !rr_last_lsu;
`else
    lsu_first = 1'b1;
`endif
    if (want_if && want_lsu) begin
      exp_gnt.push_back(lsu_first);
      exp_gnt.push_back(!lsu_first);
      exp_acc.push_back(lsu_first ? a_lsu : a_if);
      exp_acc.push_back(lsu_first ? a_if : a_lsu);
      rr_last_lsu = !lsu_first;
    end else begin
      exp_gnt.push_back(want_lsu);
      exp_acc.push_back(want_lsu ? a_lsu : a_if);
      rr_last_lsu = want_lsu;
    end
    $display("round: kind=%0d if_addr=%h lsu_we=%0b lsu_size=%0d lsu_addr=%h", kind,
             a_if.addr, a_lsu.we, a_lsu.size, a_lsu.addr);
    bus.if_req  = want_if;
    bus.lsu_req = want_lsu;
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      gi = bus.if_req && bus.if_gnt;
      gl = bus.lsu_req && bus.lsu_gnt;
      @(posedge clk);
      #1;
      if (gi) begin bus.if_req = 1'b0; bus.if_addr = $urandom; end
      if (gl) begin bus.lsu_req = 1'b0; bus.lsu_addr = $urandom; bus.lsu_wdata = $urandom; end
      if (!bus.if_req && !bus.lsu_req && n_done >= target) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check("round_timeout", 0, 1);
      bus.if_req  = 1'b0;
      bus.lsu_req = 1'b0;
    end
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_size = 2'b00;
    bus.lsu_addr = 32'h0; bus.lsu_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_busy", 32'(bus.arb_busy), 0);
    check("rst_if_done", 32'(bus.if_done), 0);
    check("rst_lsu_done", 32'(bus.lsu_done), 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_lsu_rdata", bus.lsu_rdata, 0);
    check("rst_err", 32'(bus.arb_err), 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_round(2);
    run_round(2);
    run_round(2);
    for (int r = 0; r < 60; r++) begin
      run_round($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    // Reset in the middle of a hung LSU access
    hold = 1'b1;
    bus.lsu_we = 1'b0; bus.lsu_size = 2'b10; bus.lsu_addr = 32'h2008;
    exp_gnt.push_back(1'b1);
    exp_acc.push_back('{lsu: 1'b1, we: 1'b0, size: 2'b10, addr: 32'h2008, wdata: 32'h0});
    bus.lsu_req = 1'b1;
    @(negedge clk);
    check("hold_lsu_gnt", 32'(bus.lsu_gnt), 1);
    @(posedge clk);
    #1;
    bus.lsu_req = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    $display("reset asserted mid-access at cycle %0d", cyc);
    check("midrst_mem_req", 32'(bus.mem_req), 0);
    check("midrst_busy", 32'(bus.arb_busy), 0);
    check("midrst_mem_addr", bus.mem_addr, 0);
    check("midrst_lsu_done", 32'(bus.lsu_done), 0);
    check("midrst_lsu_rdata", bus.lsu_rdata, 0);
    check("midrst_if_rdata", bus.if_rdata, 0);
    exp_gnt.delete();
    exp_acc.delete();
    exp_done.delete();
    rr_last_lsu = 1'b0;
    last_if = 32'h0;
    last_lsu = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    hold = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(bus.arb_busy), 0);
    run_round(1);
    run_round(2);
    for (int r = 0; r < 15; r++) run_round($urandom_range(0, 2));
    repeat (2) @(posedge clk);
    check("leftover_done", 32'(exp_done.size()), 0);
    check("leftover_gnt", 32'(exp_gnt.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
